instr_fetch: RTL and testbench

//  Fetch stage directly upstream of the instruction memory: owns the PC, drives
//  im_addr/im_rd_en, captures the returned word into the IF/ID register. Handles

---
 rtl/cpu_pkg.sv | 18 +
 rtl/if_perf_cnt.sv | 38 +++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, instruction/PC widths,
// the HALT opcode and the bubble instruction. Used by fetch, decode and the
// instruction memory so that all agree on widths and special encodings.
package cpu_pkg;

    localparam int PC_W = 16;
    localparam int IW   = 16;

    localparam logic [3:0]    HALT_OPC  = 4'hF;
    localparam logic [IW-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch-stage performance counters: instructions fetched and stall cycles.
// Latency: each counter updates on the posedge of the cycle its increment is high.
// Backpressure: none; counters saturate at all-ones instead of wrapping.
module if_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating increments: a counter pinned at all-ones stays there.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_inc_i && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (stall_inc_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, fills the IF/ID register,
// handles stall, branch redirect/flush and HALT. Latency: word addressed in
// cycle N lands in IF/ID at the posedge ending cycle N. Backpressure: stall_if
// freezes PC and IF/ID; branch_taken overrides it. Optional: IF_PERF_CNT_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                PC_W      = cpu_pkg::PC_W,
    parameter int                IW        = cpu_pkg::IW,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [3:0]        HALT_OPC  = cpu_pkg::HALT_OPC,
    parameter logic [IW-1:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_tgt,
    input  logic [IW-1:0]   im_instr,
    output logic [PC_W-1:0] im_addr,
    output logic            im_rd_en,
    output logic [IW-1:0]   ifid_instr,
    output logic [PC_W-1:0] ifid_pc_inc,
    output logic            ifid_valid,
    output logic            halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    if_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [PC_W-1:0] pc_inc_q, pc_inc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;

    logic [PC_W-1:0] pc_plus1;
    logic            is_halt;

    assign pc_plus1 = pc_q + PC_ONE;
    assign is_halt  = (im_instr[IW-1 -: 4] == HALT_OPC);

    // Next-state: a taken branch always wins (it also releases HALT), then
    // stall holds everything, otherwise RUN fetches and HALT drains a bubble.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_inc_d = pc_inc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HALT: begin
                if (branch_taken) begin
                    pc_d     = branch_tgt;
                    instr_d  = NOP_INSTR;
                    pc_inc_d = '0;
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                    state_d  = RUN;
                end else if (stall_if) begin
                    // hold
                end else if (state_q == RUN) begin
                    instr_d  = im_instr;
                    pc_inc_d = pc_plus1;
                    valid_d  = 1'b1;
                    if (is_halt) begin
                        // PC parks on the HALT word so a resume restarts cleanly.
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end else begin
                    instr_d  = NOP_INSTR;
                    pc_inc_d = '0;
                    valid_d  = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // PC, IF/ID and FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign im_addr     = pc_q;
    assign im_rd_en    = (state_q == RUN) && !stall_if;
    assign ifid_instr  = instr_q;
    assign ifid_pc_inc = pc_inc_q;
    assign ifid_valid  = valid_q;
    assign halted      = halted_q;

`ifdef IF_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = (state_q == RUN) && !branch_taken && !stall_if;
    assign stall_inc = (state_q == RUN) && !branch_taken && stall_if;

    if_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .fetch_inc_i (fetch_inc),
        .stall_inc_i (stall_inc),
        .fetch_cnt_o (fetch_cnt),
        .stall_cnt_o (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for boot/fetch/stall/branch/HALT,
// plus hand sequences for PC wrap, asynchronous reset and the perf counters.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        branch_taken;
    logic [15:0] branch_tgt;
    logic [15:0] im_instr;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_inc;
    logic        ifid_valid;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    logic [15:0] mem [0:65535];
    assign im_instr = mem[im_addr];

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_if     (stall_if),
        .branch_taken (branch_taken),
        .branch_tgt   (branch_tgt),
        .im_instr     (im_instr),
        .im_addr      (im_addr),
        .im_rd_en     (im_rd_en),
        .ifid_instr   (ifid_instr),
        .ifid_pc_inc  (ifid_pc_inc),
        .ifid_valid   (ifid_valid),
        .halted       (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after a posedge, then advance to the next posedge + 1.
    task automatic step(input logic s, input logic b, input logic [15:0] t);
        stall_if     = s;
        branch_taken = b;
        branch_tgt   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " im_addr"},     {16'h0, im_addr},     32'h0);
        chk({tag, " im_rd_en"},    {31'h0, im_rd_en},    32'h0);
        chk({tag, " ifid_instr"},  {16'h0, ifid_instr},  32'h0);
        chk({tag, " ifid_pc_inc"}, {16'h0, ifid_pc_inc}, 32'h0);
        chk({tag, " ifid_valid"},  {31'h0, ifid_valid},  32'h0);
        chk({tag, " halted"},      {31'h0, halted},      32'h0);
`ifdef IF_PERF_CNT_EN
        chk({tag, " fetch_cnt"},   fetch_cnt,            32'h0);
        chk({tag, " stall_cnt"},   stall_cnt,            32'h0);
`endif
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        rd;      // im_rd_en before the edge
        logic [15:0] addr;    // after the edge
        logic [15:0] instr;
        logic [15:0] pcinc;
        logic        valid;
        logic        halted;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    initial begin
        // stall br  tgt       rd  addr      instr     pcinc     v  h
        vt[0]  = '{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0}; // BOOT
        vt[1]  = '{0, 0, 16'h0000, 1, 16'h0001, 16'h1111, 16'h0001, 1, 0};
        vt[2]  = '{0, 0, 16'h0000, 1, 16'h0002, 16'h2222, 16'h0002, 1, 0};
        vt[3]  = '{1, 0, 16'h0000, 0, 16'h0002, 16'h2222, 16'h0002, 1, 0}; // stall x3
        vt[4]  = '{1, 0, 16'h0000, 0, 16'h0002, 16'h2222, 16'h0002, 1, 0};
        vt[5]  = '{1, 0, 16'h0000, 0, 16'h0002, 16'h2222, 16'h0002, 1, 0};
        vt[6]  = '{0, 0, 16'h0000, 1, 16'h0003, 16'h3333, 16'h0003, 1, 0};
        vt[7]  = '{1, 1, 16'h0040, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0}; // branch + stall
        vt[8]  = '{0, 0, 16'h0000, 1, 16'h0041, 16'hAAAA, 16'h0041, 1, 0};
        vt[9]  = '{0, 1, 16'h0003, 1, 16'h0003, 16'h0000, 16'h0000, 0, 0}; // branch back
        vt[10] = '{0, 0, 16'h0000, 1, 16'h0004, 16'h4444, 16'h0004, 1, 0};
        vt[11] = '{0, 0, 16'h0000, 1, 16'h0005, 16'h5555, 16'h0005, 1, 0};
        vt[12] = '{0, 0, 16'h0000, 1, 16'h0005, 16'hF000, 16'h0006, 1, 1}; // HALT captured
        vt[13] = '{1, 0, 16'h0000, 0, 16'h0005, 16'hF000, 16'h0006, 1, 1}; // HALT + stall hold
        vt[14] = '{0, 0, 16'h0000, 0, 16'h0005, 16'h0000, 16'h0000, 0, 1}; // bubble
        vt[15] = '{0, 0, 16'h0000, 0, 16'h0005, 16'h0000, 16'h0000, 0, 1}; // no reads
        vt[16] = '{0, 1, 16'h0010, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0}; // resume
        vt[17] = '{0, 0, 16'h0000, 1, 16'h0011, 16'h1010, 16'h0011, 1, 0};
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h0000] = 16'h1111;
        mem[16'h0001] = 16'h2222;
        mem[16'h0002] = 16'h3333;
        mem[16'h0003] = 16'h4444;
        mem[16'h0004] = 16'h5555;
        mem[16'h0005] = 16'hF000;
        mem[16'h0010] = 16'h1010;
        mem[16'h0040] = 16'hAAAA;
        mem[16'h0041] = 16'hBBBB;
        mem[16'hFFFF] = 16'h7777;

        rst          = 1'b1;
        stall_if     = 1'b0;
        branch_taken = 1'b0;
        branch_tgt   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Table-driven main stream.
        for (int i = 0; i < NV; i++) begin
            stall_if     = vt[i].stall;
            branch_taken = vt[i].br;
            branch_tgt   = vt[i].tgt;
            #2;
            chk($sformatf("v%0d rd_en", i), {31'h0, im_rd_en}, {31'h0, vt[i].rd});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d im_addr", i), {16'h0, im_addr},     {16'h0, vt[i].addr});
            chk($sformatf("v%0d instr", i),   {16'h0, ifid_instr},  {16'h0, vt[i].instr});
            chk($sformatf("v%0d pc_inc", i),  {16'h0, ifid_pc_inc}, {16'h0, vt[i].pcinc});
            chk($sformatf("v%0d valid", i),   {31'h0, ifid_valid},  {31'h0, vt[i].valid});
            chk($sformatf("v%0d halted", i),  {31'h0, halted},      {31'h0, vt[i].halted});
        end

        // PC wrap at 0xFFFF.
        step(0, 1, 16'hFFFF);
        chk("wrap redirect addr", {16'h0, im_addr}, 32'h0000_FFFF);
        step(0, 0, 16'h0000);
        chk("wrap instr",  {16'h0, ifid_instr},  32'h0000_7777);
        chk("wrap pc_inc", {16'h0, ifid_pc_inc}, 32'h0000_0000);
        chk("wrap addr",   {16'h0, im_addr},     32'h0000_0000);
        step(0, 0, 16'h0000);
        chk("post-wrap instr",  {16'h0, ifid_instr},  32'h0000_1111);
        chk("post-wrap pc_inc", {16'h0, ifid_pc_inc}, 32'h0000_0001);

        // Asynchronous reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Boot, redirect into a zero-opcode region, then 10 fetches and 4 stalls.
        step(0, 0, 16'h0000);
        step(0, 1, 16'h0020);
        for (int i = 0; i < 14; i++) begin
            step((i == 2) || (i == 5) || (i == 6) || (i == 10), 0, 16'h0000);
        end
        chk("perf run addr",   {16'h0, im_addr},     32'h0000_002A);
        chk("perf run pc_inc", {16'h0, ifid_pc_inc}, 32'h0000_002A);
        chk("perf run valid",  {31'h0, ifid_valid},  32'h1);
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'd10);
        chk("stall_cnt", stall_cnt, 32'd4);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("perf rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
